// File: rtl/pkg_tx.sv
// Packet transmit stage: buffers one packet of 16-bit words, then sends it as a
// framed byte stream (sync, id, length, data MSB-first, checksum) over ready/valid.
`timescale 1ns/1ps
module pkg_tx #(
    parameter int           DEPTH = 64,
    parameter int           AW    = 6,
    parameter logic [7:0]   SYNC  = 8'hA5
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [5:0]  dev_id,
    input  logic [15:0] pkg_d,
    input  logic        pkg_vld,
    output logic        pkg_done,
    output logic [7:0]  tx_d,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic        ovf,
    output logic [3:0]  dbg_state_o
);

    // tx byte stream: a byte moves when tx_vld && tx_rdy; tx_vld/tx_d never change while stalled.
    typedef enum logic [3:0] {
        S_IDLE, S_RECV, S_HDR0, S_HDR1, S_LEN, S_DATH, S_DATL, S_SUM, S_DONE
    } state_t;

    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_ONE  = 1;

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [5:0]    id_q, id_d;
    logic          ovf_q, ovf_d;
    logic          ovf_seen_q, ovf_seen_d;
    logic [7:0]    tx_d_q, tx_d_d;
    logic          tx_vld_q, tx_vld_d;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [15:0]   rd_word;
    logic          xfer;

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_sys) begin
        if (we) mem_q[wr_addr] <= pkg_d;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            id_q       <= '0;
            ovf_q      <= 1'b0;
            ovf_seen_q <= 1'b0;
            tx_d_q     <= '0;
            tx_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            id_q       <= id_d;
            ovf_q      <= ovf_d;
            ovf_seen_q <= ovf_seen_d;
            tx_d_q     <= tx_d_d;
            tx_vld_q   <= tx_vld_d;
        end
    end

    assign xfer = tx_vld_q && tx_rdy;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        id_d       = id_q;
        ovf_d      = 1'b0;
        ovf_seen_d = ovf_seen_q;
        we         = 1'b0;
        wr_addr    = '0;
        case (state_q)
            S_IDLE: begin
                count_d    = '0;
                idx_d      = '0;
                sum_d      = '0;
                ovf_seen_d = 1'b0;
                if (pkg_vld) begin
                    we      = 1'b1;
                    count_d = CNT_ONE;
                    id_d    = dev_id;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (!pkg_vld) begin
                    state_d = S_HDR0;
                end else if (count_q < CNT_FULL) begin
                    we      = 1'b1;
                    wr_addr = count_q[AW-1:0];
                    count_d = count_q + CNT_ONE;
                end else if (!ovf_seen_q) begin
                    ovf_d      = 1'b1;
                    ovf_seen_d = 1'b1;
                end
            end
            S_HDR0: if (xfer) state_d = S_HDR1;
            S_HDR1: if (xfer) begin
                sum_d   = sum_q + tx_d_q;
                state_d = S_LEN;
            end
            S_LEN: if (xfer) begin
                sum_d   = sum_q + tx_d_q;
                idx_d   = '0;
                state_d = S_DATH;
            end
            S_DATH: if (xfer) begin
                sum_d   = sum_q + tx_d_q;
                state_d = S_DATL;
            end
            S_DATL: if (xfer) begin
                sum_d = sum_q + tx_d_q;
                if ({1'b0, idx_q} + CNT_ONE == count_q) begin
                    state_d = S_SUM;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_DATH;
                end
            end
            S_SUM: if (xfer) state_d = S_DONE;
            S_DONE: begin
                count_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The output register is loaded with the byte of the state being entered,
    // so the buffer is read asynchronously at the next index.
    assign rd_word = mem_q[idx_d];

    always_comb begin
        tx_d_d   = '0;
        tx_vld_d = 1'b0;
        pkg_done = (state_q == S_DONE);
        case (state_d)
            S_HDR0: begin tx_vld_d = 1'b1; tx_d_d = SYNC; end
            S_HDR1: begin tx_vld_d = 1'b1; tx_d_d = {2'b00, id_d}; end
            S_LEN:  begin tx_vld_d = 1'b1; tx_d_d = 8'(count_d); end
            S_DATH: begin tx_vld_d = 1'b1; tx_d_d = rd_word[15:8]; end
            S_DATL: begin tx_vld_d = 1'b1; tx_d_d = rd_word[7:0]; end
            S_SUM:  begin tx_vld_d = 1'b1; tx_d_d = sum_d; end
            default: ;
        endcase
    end

    assign tx_d        = tx_d_q;
    assign tx_vld      = tx_vld_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pkg_tx.sv
// Directed bench for pkg_tx: frames checked byte-by-byte against an expected queue.
`timescale 1ns/1ps
module tb_pkg_tx;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [5:0]  dev_id;
    logic [15:0] pkg_d;
    logic        pkg_vld;
    logic        pkg_done;
    logic [7:0]  tx_d;
    logic        tx_vld;
    logic        tx_rdy;
    logic        ovf;
    logic [3:0]  dbg_state_o;

    pkg_tx dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .dev_id      (dev_id),
        .pkg_d       (pkg_d),
        .pkg_vld     (pkg_vld),
        .pkg_done    (pkg_done),
        .tx_d        (tx_d),
        .tx_vld      (tx_vld),
        .tx_rdy      (tx_rdy),
        .ovf         (ovf),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] words [128];
    int          byte_cnt = 0;
    int          done_cnt = 0;
    int          ovf_cnt  = 0;
    int          ovf_at   = -1;
    int          drv_idx  = 0;
    logic        done_exp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard / monitor on the falling edge, away from the active edge.
    always @(negedge clk_sys) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            done_exp   = 1'b0;
        end else begin
            if (pkg_done || done_exp) check("done_pulse", 32'(pkg_done), 32'(done_exp));
            if (pkg_done) done_cnt++;
            if (ovf) begin
                ovf_cnt++;
                ovf_at = drv_idx - 1;
            end
            if (prev_stall) begin
                check("hold_vld", 32'(tx_vld), 32'd1);
                check("hold_d", 32'(tx_d), 32'(prev_d));
            end
            done_exp = 1'b0;
            if (tx_vld && tx_rdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("byte", 32'(tx_d), 32'(exp_q.pop_front()));
                    byte_cnt++;
                    if (exp_q.size() == 0) done_exp = 1'b1;
                end
            end
            prev_stall = tx_vld && !tx_rdy;
            prev_d     = tx_d;
        end
    end

    // Reference frame built from the word list: sync, id, len, data MSB-first, sum.
    task automatic push_frame(input logic [5:0] id, input int n);
        int         l;
        logic [7:0] s;
        logic [7:0] b;
        l = (n > 64) ? 64 : n;
        s = '0;
        exp_q.push_back(8'hA5);
        b = {2'b00, id};  exp_q.push_back(b); s = s + b;
        b = 8'(l);        exp_q.push_back(b); s = s + b;
        for (int i = 0; i < l; i++) begin
            b = words[i][15:8]; exp_q.push_back(b); s = s + b;
            b = words[i][7:0];  exp_q.push_back(b); s = s + b;
        end
        exp_q.push_back(s);
    endtask

    task automatic send_pkt(input logic [5:0] id, input int n);
        byte_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys); #1;
            pkg_vld = 1'b1;
            pkg_d   = words[i];
            dev_id  = (i == 0) ? id : ~id;
            drv_idx = i;
        end
        @(posedge clk_sys); #1;
        pkg_vld = 1'b0;
        pkg_d   = '0;
        drv_idx = n;
    endtask

    task automatic wait_done(input int d0, input int budget, input int nbytes);
        for (int c = 0; c < budget && done_cnt == d0; c++) begin
            @(posedge clk_sys); #1;
        end
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("frame_left", 32'(exp_q.size()), 32'd0);
        check("frame_len", 32'(byte_cnt), 32'(nbytes));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int o0;
        logic [7:0] basic [8];
        logic [7:0] single [6];
        basic  = '{8'hA5, 8'h05, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC5};
        single = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00};
        rst_n = 1'b0; dev_id = '0; pkg_d = '0; pkg_vld = 1'b0; tx_rdy = 1'b1;
        #1;
        check("rst_tx_d", 32'(tx_d), 32'd0);
        check("rst_tx_vld", 32'(tx_vld), 32'd0);
        check("rst_done", 32'(pkg_done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;

        // Basic frame with turnaround timing
        words[0] = 16'h1234; words[1] = 16'hABCD;
        foreach (basic[i]) exp_q.push_back(basic[i]);
        d0 = done_cnt;
        send_pkt(6'd5, 2);
        @(negedge clk_sys);
        check("turn_pre", 32'(tx_vld), 32'd0);
        @(negedge clk_sys);
        check("turn_vld", 32'(tx_vld), 32'd1);
        check("turn_sync", 32'(tx_d), 32'hA5);
        wait_done(d0, 50, 8);

        // Single word
        words[0] = 16'h00FF;
        foreach (single[i]) exp_q.push_back(single[i]);
        d0 = done_cnt;
        send_pkt(6'd0, 1);
        wait_done(d0, 50, 6);

        // Overflow: 70 words, only 64 kept
        for (int i = 0; i < 70; i++) words[i] = 16'(i);
        push_frame(6'h2A, 70);
        d0 = done_cnt; o0 = ovf_cnt;
        send_pkt(6'h2A, 70);
        wait_done(d0, 400, 132);
        check("ovf_count", 32'(ovf_cnt - o0), 32'd1);
        check("ovf_word", 32'(ovf_at), 32'd64);

        // Backpressure: stall 10 cycles at first DATL, then random ready
        words[0] = 16'hC001; words[1] = 16'h0203; words[2] = 16'hFFEE; words[3] = 16'h8070;
        push_frame(6'h3F, 4);
        d0 = done_cnt;
        send_pkt(6'h3F, 4);
        for (int c = 0; c < 50 && byte_cnt < 4; c++) begin
            @(posedge clk_sys); #1;
        end
        check("bp_reach_datl", 32'(byte_cnt), 32'd4);
        tx_rdy = 1'b0;
        for (int c = 0; c < 400 && done_cnt == d0; c++) begin
            @(posedge clk_sys); #1;
            tx_rdy = (c < 9) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        tx_rdy = 1'b1;
        wait_done(d0, 20, 12);

        // Words during transmit are ignored
        words[0] = 16'h0102; words[1] = 16'h0304; words[2] = 16'h0506;
        push_frame(6'h11, 3);
        d0 = done_cnt; o0 = ovf_cnt;
        send_pkt(6'h11, 3);
        @(posedge clk_sys); #1; pkg_vld = 1'b1; pkg_d = 16'hDEAD;
        @(posedge clk_sys); #1; pkg_d = 16'hBEEF;
        @(posedge clk_sys); #1; pkg_vld = 1'b0; pkg_d = '0;
        wait_done(d0, 50, 10);
        check("ign_ovf", 32'(ovf_cnt - o0), 32'd0);
        words[0] = 16'h5566; words[1] = 16'h7788;
        push_frame(6'h22, 2);
        d0 = done_cnt;
        send_pkt(6'h22, 2);
        wait_done(d0, 50, 8);

        // Reset during DATH
        words[0] = 16'hAAAA; words[1] = 16'h5555; words[2] = 16'h1111; words[3] = 16'h2222;
        push_frame(6'h07, 4);
        d0 = done_cnt;
        send_pkt(6'h07, 4);
        for (int c = 0; c < 50 && byte_cnt < 3; c++) begin
            @(posedge clk_sys); #1;
        end
        check("rst_reach_dath", 32'(byte_cnt), 32'd3);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_vld", 32'(tx_vld), 32'd0);
        check("mid_rst_d", 32'(tx_d), 32'd0);
        check("mid_rst_done", 32'(pkg_done), 32'd0);
        check("mid_rst_state", 32'(dbg_state_o), 32'd0);
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_idle_vld", 32'(tx_vld), 32'd0);
        words[0] = 16'h0F0F; words[1] = 16'hF0F0;
        push_frame(6'h3C, 2);
        d0 = done_cnt;
        send_pkt(6'h3C, 2);
        wait_done(d0, 50, 8);

        repeat (3) @(posedge clk_sys);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/pkg_tx.md
# pkg_tx

Packet transmit stage directly downstream of the packet assembler. It captures one packet of 16-bit words presented on the `pkg_d`/`pkg_vld` stream into a local buffer. It then serialises the packet as a framed byte stream (sync, device ID, length, data MSB-first, checksum) onto a ready/valid byte interface toward the host link. When the frame is fully sent, it returns a one-cycle `pkg_done` so the assembler may present the next packet.

## Interface
- `DEPTH`, 64: packet buffer depth in 16-bit words; power of two, at most 128.
- `AW`, 6: buffer address width, log2(`DEPTH`).
- `SYNC`, 8'hA5: frame sync byte.

Ports:
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `dev_id`  in  6  device ID; sampled when the packet's first word is accepted.
- `pkg_d`  in  16  packet data word.
- `pkg_vld`  in  1  word valid; held high for consecutive cycles, one word per cycle; the first low cycle ends the packet.
- `pkg_done`  out  1  one-cycle pulse after the last frame byte (checksum) is accepted.
- `tx_d`  out  8  frame byte.
- `tx_vld`  out  1  frame byte valid.
- `tx_rdy`  in  1  sink ready; a byte transfers when `tx_vld && tx_rdy`.
- `ovf`  out  1  one-cycle pulse on the first word dropped because the buffer is full.

## Operation
- Reset values:
  - `tx_d` = 0, `tx_vld` = 0, `pkg_done` = 0, `ovf` = 0.
  - State = IDLE; word count = 0; checksum = 0.
- **IDLE:** `pkg_vld` = 1 writes `pkg_d` to `buf[0]`, sets count = 1, latches `dev_id`, and moves to RECV.
- **RECV:**
  - While `pkg_vld` = 1 and count < `DEPTH`: write `buf[count]` and increment count.
  - While `pkg_vld` = 1 and count == `DEPTH`: drop the word; pulse `ovf` on the first drop only (at most once per packet).
  - On `pkg_vld` = 0: go to HDR0.
- **Frame states**, in order: HDR0 -> HDR1 -> LEN -> then (DATH -> DATL) × count -> SUM -> DONE -> IDLE.
- Frame bytes:
  - HDR0 = `SYNC`
  - HDR1 = {2'b00, latched `dev_id`}
  - LEN = count[7:0]
  - DATH = `buf[i]`[15:8]
  - DATL = `buf[i]`[7:0]
  - SUM = checksum
- Each frame state advances only on the cycle where `tx_vld && tx_rdy`. `tx_vld` stays high from HDR0 through SUM.
- Checksum:
  - 8-bit sum, modulo 256, of every byte transferred after HDR0 (HDR1 through the last DATL).
  - Cleared in IDLE; accumulates on each accepted byte.
- Data index `i` runs 0..count-1 and increments after each accepted DATL. Leave DATL for SUM when `i` == count-1.
- **DONE:** `pkg_done` = 1 for exactly one cycle, then IDLE. Count is reset to 0.
- `pkg_vld` outside IDLE and RECV (frame states and DONE) is ignored. Those words are not stored and do not raise `ovf`; upstream must wait for `pkg_done`.
- Buffer: a single-port-write / single-port-read RAM, inferable as distributed or block RAM. The read address must be presented early enough that `tx_d` is valid on the cycle `tx_vld` rises in DATH.

## Timing
- Receive: one word per cycle, zero wait states; `pkg_vld` has no backpressure.
- Receive-to-transmit turnaround:
  - `pkg_vld` first low at cycle N: state is HDR0 at N+1.
  - `tx_vld` = 1 with `tx_d` = `SYNC` at N+1, registered.
- Throughput: one byte per cycle while `tx_rdy` = 1. A packet of L words takes 2L+4 accepted bytes.
- Backpressure: while `tx_vld` = 1 and `tx_rdy` = 0, `tx_d` and `tx_vld` are held stable; no byte is skipped or duplicated.
- `pkg_done` rises the cycle after SUM is accepted. Earliest next packet acceptance is the cycle after `pkg_done`.
- Asynchronous reset mid-packet or mid-frame:
  - All outputs go to their reset values immediately.
  - The partial frame is abandoned; no `pkg_done` is produced.
  - Buffer contents are don't-care.

## Test plan
- **Basic frame:** `dev_id` = 5; words 16'h1234, 16'hABCD on 2 consecutive cycles; `tx_rdy` = 1 -> bytes A5 05 02 12 34 AB CD C5 on 8 consecutive cycles, starting the cycle after `pkg_vld` falls; `pkg_done` pulses once the following cycle.
- **Single word:** 16'h00FF, `dev_id` = 0 -> bytes A5 00 01 00 FF 00.
- **Overflow:** 70 consecutive words 0..69 -> `ovf` pulses once, on the 65th word; LEN = 8'h40; data 0..63 only; checksum matches the bytes sent.
- **Backpressure:** 4-word packet; `tx_rdy` low for 10 cycles at the first DATL and randomly toggled thereafter -> byte sequence identical to the `tx_rdy` = 1 run; `tx_d` stable while stalled.
- **Words during transmit:** `pkg_vld` pulsed during a frame -> ignored; the frame is unchanged; the next packet after `pkg_done` is framed correctly.
- **Reset mid-frame:** `rst_n` low during DATH -> `tx_vld` = 0 at once; no `pkg_done`; the next packet after reset release produces a correct frame.
